// File: rtl/link_timing_sequencer.sv
// Transaction timing sequencer for the transceiver: guard delay, frame transmit,
// response window with timeout, and bounded retries around the microsecond delay counter.
module link_timing_sequencer #(
  parameter int unsigned WIDE      = 32,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RW        = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [WIDE-1:0] guard_us,
  input  logic [WIDE-1:0] timeout_us,
  output logic            busy,
  output logic            tx_start,
  input  logic            tx_done,
  input  logic            rx_frame,
  input  logic            rx_crc_ok,
  output logic            tmr_start,
  output logic [WIDE-1:0] tmr_count,
  input  logic            tmr_done,
  output logic            done,
  output logic [1:0]      status,
  output logic [RW-1:0]   retries_used
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GUARD    = 3'd1,
    S_TX       = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  localparam logic [RW-1:0] MAX_R      = RW'(MAX_RETRY);
  localparam logic [1:0]    ST_OK      = 2'b00;
  localparam logic [1:0]    ST_TIMEOUT = 2'b01;
  localparam logic [1:0]    ST_CRC     = 2'b10;

  state_t          r_state;
  logic [WIDE-1:0] r_guard;
  logic [WIDE-1:0] r_timeout;
  logic [RW-1:0]   r_retry_cnt;
  logic            r_busy;
  logic            r_tx_start;
  logic            r_tmr_start;
  logic            r_tmr_blank;
  logic [WIDE-1:0] r_tmr_count;
  logic            r_done;
  logic [1:0]      r_status;
  logic [RW-1:0]   r_retries_used;

  state_t          w_state;
  logic [WIDE-1:0] w_guard;
  logic [WIDE-1:0] w_timeout;
  logic [RW-1:0]   w_retry_cnt;
  logic            w_busy;
  logic            w_tx_start;
  logic            w_tmr_start;
  logic [WIDE-1:0] w_tmr_count;
  logic            w_done;
  logic [1:0]      w_status;
  logic [RW-1:0]   w_retries_used;

  logic            w_tmr_ok;
  logic            w_accept;
  logic            w_guard_exp;
  logic            w_tx_fin;
  logic            w_ok;
  logic            w_fail;
  logic [1:0]      w_cause;
  logic            w_to_idle;
  logic            w_retry;
  logic            w_give_up;
  logic            w_launch;
  logic [WIDE-1:0] w_launch_guard;
  logic            w_launch_nz;

  // Decode the per-state events, then derive every next-state and next-output value.
  always_comb begin
    w_accept    = 1'b0;
    w_guard_exp = 1'b0;
    w_tx_fin    = 1'b0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_cause     = ST_TIMEOUT;
    w_to_idle   = 1'b0;

    // A count_done in the start cycle or the one after may belong to the previous delay.
    w_tmr_ok = tmr_done & ~r_tmr_start & ~r_tmr_blank;

    case (r_state)
      S_IDLE:     w_accept    = req;
      S_GUARD:    w_guard_exp = w_tmr_ok;
      S_TX:       w_tx_fin    = tx_done;
      S_WAIT_RSP: begin
        w_ok    = rx_frame & rx_crc_ok;
        w_fail  = (rx_frame & ~rx_crc_ok) | (~rx_frame & w_tmr_ok);
        w_cause = rx_frame ? ST_CRC : ST_TIMEOUT;
      end
      S_FIN:      w_to_idle   = 1'b1;
      default:    w_to_idle   = 1'b1;
    endcase

    w_retry        = w_fail & (r_retry_cnt < MAX_R);
    w_give_up      = w_fail & ~(r_retry_cnt < MAX_R);
    w_done         = w_ok | w_give_up;
    w_launch       = w_accept | w_retry;
    w_launch_guard = w_accept ? guard_us : r_guard;
    w_launch_nz    = (w_launch_guard != {WIDE{1'b0}});

    w_tmr_start = (w_launch & w_launch_nz) | w_tx_fin;
    w_tx_start  = (w_launch & ~w_launch_nz) | w_guard_exp;

    if (w_launch && w_launch_nz) begin
      w_tmr_count = w_launch_guard;
    end else if (w_tx_fin) begin
      w_tmr_count = r_timeout;
    end else begin
      w_tmr_count = r_tmr_count;
    end

    if (w_done) begin
      w_state = S_FIN;
    end else if (w_launch && w_launch_nz) begin
      w_state = S_GUARD;
    end else if (w_launch || w_guard_exp) begin
      w_state = S_TX;
    end else if (w_tx_fin) begin
      w_state = S_WAIT_RSP;
    end else if (w_to_idle) begin
      w_state = S_IDLE;
    end else begin
      w_state = r_state;
    end

    if (w_accept) begin
      w_guard   = guard_us;
      w_timeout = timeout_us;
    end else begin
      w_guard   = r_guard;
      w_timeout = r_timeout;
    end

    if (w_accept) begin
      w_retry_cnt = {RW{1'b0}};
    end else if (w_retry) begin
      w_retry_cnt = r_retry_cnt + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      w_retry_cnt = r_retry_cnt;
    end

    if (w_accept) begin
      w_busy = 1'b1;
    end else if (w_to_idle) begin
      w_busy = 1'b0;
    end else begin
      w_busy = r_busy;
    end

    if (w_accept) begin
      w_status = ST_OK;
    end else if (w_done) begin
      w_status = w_give_up ? w_cause : ST_OK;
    end else begin
      w_status = r_status;
    end

    if (w_done) begin
      w_retries_used = r_retry_cnt;
    end else begin
      w_retries_used = r_retries_used;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_guard        <= {WIDE{1'b0}};
      r_timeout      <= {WIDE{1'b0}};
      r_retry_cnt    <= {RW{1'b0}};
      r_busy         <= 1'b0;
      r_tx_start     <= 1'b0;
      r_tmr_start    <= 1'b0;
      r_tmr_blank    <= 1'b0;
      r_tmr_count    <= {WIDE{1'b0}};
      r_done         <= 1'b0;
      r_status       <= 2'b00;
      r_retries_used <= {RW{1'b0}};
    end else begin
      r_state        <= w_state;
      r_guard        <= w_guard;
      r_timeout      <= w_timeout;
      r_retry_cnt    <= w_retry_cnt;
      r_busy         <= w_busy;
      r_tx_start     <= w_tx_start;
      r_tmr_start    <= w_tmr_start;
      r_tmr_blank    <= r_tmr_start;
      r_tmr_count    <= w_tmr_count;
      r_done         <= w_done;
      r_status       <= w_status;
      r_retries_used <= w_retries_used;
    end
  end

  assign busy         = r_busy;
  assign tx_start     = r_tx_start;
  assign tmr_start    = r_tmr_start;
  assign tmr_count    = r_tmr_count;
  assign done         = r_done;
  assign status       = r_status;
  assign retries_used = r_retries_used;

endmodule

// File: tb/tb_link_timing_sequencer.sv
// Directed self-checking bench for link_timing_sequencer; the bench plays the
// delay counter, serializer and receiver by hand.
module tb_link_timing_sequencer;

  localparam int WIDE      = 32;
  localparam int MAX_RETRY = 3;
  localparam int RW        = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic [WIDE-1:0] guard_us;
  logic [WIDE-1:0] timeout_us;
  logic            busy;
  logic            tx_start;
  logic            tx_done;
  logic            rx_frame;
  logic            rx_crc_ok;
  logic            tmr_start;
  logic [WIDE-1:0] tmr_count;
  logic            tmr_done;
  logic            done;
  logic [1:0]      status;
  logic [RW-1:0]   retries_used;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int              n_tx    = 0;
  int              n_tmr   = 0;
  int              n_guard = 0;
  int              n_done  = 0;
  logic [WIDE-1:0] mon_guard = '0;

  int b_tx;
  int b_tmr;
  int b_guard;
  int b_done;

  link_timing_sequencer #(
    .WIDE(WIDE), .MAX_RETRY(MAX_RETRY), .RW(RW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .guard_us(guard_us), .timeout_us(timeout_us),
    .busy(busy), .tx_start(tx_start), .tx_done(tx_done), .rx_frame(rx_frame),
    .rx_crc_ok(rx_crc_ok), .tmr_start(tmr_start), .tmr_count(tmr_count),
    .tmr_done(tmr_done), .done(done), .status(status), .retries_used(retries_used)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) n_tx <= n_tx + 1;
      if (tmr_start) n_tmr <= n_tmr + 1;
      if (tmr_start && (tmr_count == mon_guard)) n_guard <= n_guard + 1;
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tmr_start"}, 32'(tmr_start), 32'd0);
    chk({tag, "_tmr_count"}, tmr_count, 32'd0);
    chk({tag, "_status"}, 32'(status), 32'd0);
    chk({tag, "_retries"}, 32'(retries_used), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; guard_us = '0; timeout_us = '0;
    tx_done = 1'b0; rx_frame = 1'b0; rx_crc_ok = 1'b0; tmr_done = 1'b0;
    tick(3);
    chk_idle_outputs("reset");
    rst = 1'b1;
    tick(2);

    // Nominal exchange: guard 5, timeout 20, good response mid-window.
    mon_guard = 32'd5; b_tx = n_tx; b_tmr = n_tmr;
    guard_us = 32'd5; timeout_us = 32'd20; req = 1'b1;
    tick; req = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_guard_start", 32'(tmr_start), 32'd1);
    chk("t1_guard_count", tmr_count, 32'd5);
    chk("t1_no_tx_yet", 32'(tx_start), 32'd0);
    tick(3);
    tmr_done = 1'b1; tick; tmr_done = 1'b0;
    chk("t1_tx_start", 32'(tx_start), 32'd1);
    tick(9);
    tx_done = 1'b1; tick; tx_done = 1'b0;
    chk("t1_win_start", 32'(tmr_start), 32'd1);
    chk("t1_win_count", tmr_count, 32'd20);
    tick(4);
    rx_frame = 1'b1; rx_crc_ok = 1'b1; tick; rx_frame = 1'b0; rx_crc_ok = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_status", 32'(status), 32'd0);
    chk("t1_retries", 32'(retries_used), 32'd0);
    chk("t1_busy_with_done", 32'(busy), 32'd1);
    tick;
    chk("t1_done_drop", 32'(done), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_tx_pulses", 32'(n_tx - b_tx), 32'd1);
    chk("t1_tmr_pulses", 32'(n_tmr - b_tmr), 32'd2);

    // Zero guard, never any response: four attempts then TIMEOUT.
    b_tx = n_tx; b_tmr = n_tmr;
    guard_us = 32'd0; timeout_us = 32'd3; req = 1'b1;
    tick; req = 1'b0;
    chk("t2_tx_immediate", 32'(tx_start), 32'd1);
    chk("t2_no_guard_tmr", 32'(tmr_start), 32'd0);
    for (int a = 0; a < 4; a++) begin
      tick(2);
      tx_done = 1'b1; tick; tx_done = 1'b0;
      chk("t2_win_start", 32'(tmr_start), 32'd1);
      tick(2);
      tmr_done = 1'b1; tick; tmr_done = 1'b0;
      if (a < 3) begin
        chk("t2_retry_tx", 32'(tx_start), 32'd1);
      end else begin
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_status", 32'(status), 32'd1);
        chk("t2_retries", 32'(retries_used), 32'd3);
      end
    end
    tick;
    chk("t2_busy_drop", 32'(busy), 32'd0);
    chk("t2_tx_pulses", 32'(n_tx - b_tx), 32'd4);
    chk("t2_tmr_pulses", 32'(n_tmr - b_tmr), 32'd4);
    tick(3);
    chk("t2_status_held", 32'(status), 32'd1);
    chk("t2_retries_held", 32'(retries_used), 32'd3);

    // CRC error on the first response, good on the retry.
    mon_guard = 32'd2; b_guard = n_guard; b_tx = n_tx;
    guard_us = 32'd2; timeout_us = 32'd10; req = 1'b1;
    tick; req = 1'b0;
    chk("t3_status_cleared", 32'(status), 32'd0);
    chk("t3_guard_count", tmr_count, 32'd2);
    tick(2);
    tmr_done = 1'b1; tick; tmr_done = 1'b0;
    chk("t3_tx1", 32'(tx_start), 32'd1);
    tx_done = 1'b1; tick; tx_done = 1'b0;
    tick;
    rx_frame = 1'b1; rx_crc_ok = 1'b0; tick; rx_frame = 1'b0;
    chk("t3_retry_guard", 32'(tmr_start), 32'd1);
    chk("t3_retry_count", tmr_count, 32'd2);
    chk("t3_no_done", 32'(done), 32'd0);
    tick(2);
    tmr_done = 1'b1; tick; tmr_done = 1'b0;
    chk("t3_tx2", 32'(tx_start), 32'd1);
    tx_done = 1'b1; tick; tx_done = 1'b0;
    tick(2);
    rx_frame = 1'b1; rx_crc_ok = 1'b1; tick; rx_frame = 1'b0; rx_crc_ok = 1'b0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_status", 32'(status), 32'd0);
    chk("t3_retries", 32'(retries_used), 32'd1);
    tick;
    chk("t3_guard_timers", 32'(n_guard - b_guard), 32'd2);
    chk("t3_tx_pulses", 32'(n_tx - b_tx), 32'd2);

    // rx_frame coincident with expiry wins; req during FIN is dropped.
    b_tx = n_tx;
    guard_us = 32'd0; timeout_us = 32'd1; req = 1'b1;
    tick; req = 1'b0;
    tx_done = 1'b1; tick; tx_done = 1'b0;
    tick(2);
    rx_frame = 1'b1; rx_crc_ok = 1'b1; tmr_done = 1'b1;
    tick;
    rx_frame = 1'b0; rx_crc_ok = 1'b0; tmr_done = 1'b0; req = 1'b1;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_status", 32'(status), 32'd0);
    chk("t4_retries", 32'(retries_used), 32'd0);
    tick; req = 1'b0;
    chk("t4_fin_req_busy", 32'(busy), 32'd0);
    chk("t4_fin_req_tx", 32'(tx_start), 32'd0);
    tick;
    chk("t4_not_queued", 32'(busy), 32'd0);
    chk("t4_tx_pulses", 32'(n_tx - b_tx), 32'd1);

    // Stale tmr_done during blanking and in TX, then reset in WAIT_RSP.
    guard_us = 32'd4; timeout_us = 32'd6; req = 1'b1;
    tick; req = 1'b0;
    tmr_done = 1'b1;
    tick;
    chk("t5_blank_start", 32'(tx_start), 32'd0);
    tick;
    chk("t5_blank_next", 32'(tx_start), 32'd0);
    tmr_done = 1'b0; tick;
    tmr_done = 1'b1; tick;
    chk("t5_guard_exp", 32'(tx_start), 32'd1);
    tick(2); tmr_done = 1'b0;
    chk("t5_tx_ignore_tmr", 32'(tmr_start), 32'd0);
    chk("t5_tx_no_done", 32'(done), 32'd0);
    tx_done = 1'b1; tick; tx_done = 1'b0;
    chk("t5_win_start", 32'(tmr_start), 32'd1);
    chk("t5_win_count", tmr_count, 32'd6);
    tick;
    b_done = n_done;
    rst = 1'b0; tick;
    chk_idle_outputs("t6_midreset");
    rst = 1'b1; tick(3);
    chk("t6_no_done", 32'(n_done - b_done), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    guard_us = 32'd0; timeout_us = 32'd2; req = 1'b1;
    tick; req = 1'b0;
    chk("t6_tx_start", 32'(tx_start), 32'd1);
    chk("t6_busy", 32'(busy), 32'd1);
    tx_done = 1'b1; tick; tx_done = 1'b0;
    tick;
    rx_frame = 1'b1; rx_crc_ok = 1'b1; tick; rx_frame = 1'b0; rx_crc_ok = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_status", 32'(status), 32'd0);
    chk("t6_retries", 32'(retries_used), 32'd0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
